maxpool_ctrl: RTL and testbench
===============================

MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

Interface
REQ-001 SHALL have parameter N, default 32: data width, signed, matching the maxpool datapath.
REQ-002 SHALL have parameter W, default 4: width of the window-length field.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: upstream element available.
REQ-006 SHALL have port in_ready, output, 1: controller accepts element this cycle.
REQ-007 SHALL have port in_data, input, N: signed element.
REQ-008 SHALL have port win_size, input, W: elements per window, sampled at window start.
REQ-009 SHALL have port flush, input, 1: close the current partial window.
REQ-010 SHALL have ports max_en, max_clr and max_pool, each output, 1: drive the maxpool datapath.
REQ-011 SHALL have port max_i, output, N: datapath input.
REQ-012 SHALL have port max_o, input, N: datapath registered result.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, N): pooled-result handshake.

Function
REQ-014 in_ready SHALL equal (!out_valid || out_ready); an accept is in_valid && in_ready.
REQ-015 max_en SHALL equal accept (combinational); max_i SHALL equal in_data.
REQ-016 max_pool SHALL be 0 when cnt==0 (first element of a window, plain set) and 1 otherwise; no clear pulse is used between windows.
REQ-017 At an accept with cnt==0, win_q SHALL latch win_size, and win_size==0 SHALL be treated as 1.
REQ-018 cnt (W bits) SHALL increment on each accept and return to 0 on the accept where cnt==win_q-1 (last element).
REQ-019 On a last-element accept, out_valid SHALL be 1 in the following cycle (1-cycle latency), and out_data SHALL equal max_o, a combinational pass-through.
REQ-020 out_valid SHALL hold, with max_en low, until out_valid && out_ready; it SHALL then clear unless a new window closes on the same edge.
REQ-021 Output transfer and a new-window accept in the same cycle SHALL both occur, giving full throughput with no bubble.
REQ-022 flush with cnt>0 and no accept SHALL close the window: cnt:=0 and out_valid:=1 next cycle with the partial maximum.
REQ-023 flush together with an accept SHALL include that element and then close the window.
REQ-024 flush with cnt==0 and no accept SHALL be ignored.
REQ-025 flush SHALL be honoured only when in_ready is 1; otherwise it is ignored.
REQ-026 max_clr SHALL equal !rst_n, and SHALL be 0 at all other times.
REQ-027 State machine states: IDLE (cnt==0, !out_valid), ACC (cnt>0), HOLD (out_valid && !out_ready); ACC and HOLD may coexist.

Reset
REQ-028 While rst_n is low: cnt:=0, win_q:=1, out_valid:=0, max_en:=0, max_pool:=0, and max_clr:=1, so the datapath is cleared asynchronously.
REQ-029 A reset asserted mid-window SHALL discard the partial window and any held result, with no out_valid after release.

Structure
REQ-030 A shared maxpool_pkg header SHALL hold the state encodings and the default N/W values.
REQ-031 The module SHALL be controller-only; a wrapper maxpool_unit SHALL instantiate maxpool_ctrl plus the maxpool datapath, wiring max_* ports.

Verification
REQ-032 win_size=4, in_data 3,-7,9,2 back-to-back with out_ready=1 -> one out_valid pulse, out_data=9, max_pool sequence 0,1,1,1.
REQ-033 win_size=2, inputs -5,-3,-8,-1 continuous with out_ready=1 -> out_data -3 then -1, in_ready never low.
REQ-034 win_size=3, inputs 1,4,2 with out_ready=0 for 3 cycles -> out_data=4 stable, in_ready=0 and max_en=0 throughout the stall, transfer on release.
REQ-035 win_size=8, inputs 6,11 then flush -> out_data=11 next cycle, cnt=0, next input is accepted with max_pool=0.
REQ-036 win_size=0, input 5 -> out_data=5 after 1 cycle (treated as window length 1).
REQ-037 rst_n low after 2 of 4 elements -> max_clr=1, no out_valid; after release a full window 1,2,3,4 -> out_data=4.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared definitions for the maxpool controller, datapath and wrapper:
// default widths and the controller state encoding.
package maxpool_pkg;

  localparam int N_DEF = 32;
  localparam int W_DEF = 4;

  // Bit 0: a partial window is open (cnt > 0); bit 1: a result is held on the output.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACC      = 2'd1,
    ST_HOLD     = 2'd2,
    ST_ACC_HOLD = 2'd3
  } state_e;

  function automatic state_e state_of(input logic acc, input logic hold);
    return state_e'({hold, acc});
  endfunction

endpackage

// File: rtl/maxpool.sv
// Signed running-maximum datapath: loads max_i when max_pool is low, keeps the
// larger of the register and max_i when max_pool is high; max_clr clears asynchronously.
module maxpool
  import maxpool_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         max_clr,
  input  logic         max_en,
  input  logic         max_pool,
  input  logic [N-1:0] max_i,
  output logic [N-1:0] max_o
);

  logic [N-1:0] res_q;
  logic [N-1:0] res_d;

  always_comb begin
    res_d = res_q;
    if (max_en) begin
      if (max_pool && ($signed(res_q) > $signed(max_i))) begin
        res_d = res_q;
      end else begin
        res_d = max_i;
      end
    end
  end

  always_ff @(posedge clk or posedge max_clr) begin
    if (max_clr) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign max_o = res_q;

endmodule

// File: rtl/maxpool_unit.sv
// Complete pooling unit: the window controller driving the running-maximum datapath.
module maxpool_unit
  import maxpool_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [W-1:0] win_size,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output state_e       dbg_state
);

  logic         max_en;
  logic         max_clr;
  logic         max_pool;
  logic [N-1:0] max_i;
  logic [N-1:0] max_o;

  maxpool_ctrl #(.N(N), .W(W)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .win_size  (win_size),
    .flush     (flush),
    .max_en    (max_en),
    .max_clr   (max_clr),
    .max_pool  (max_pool),
    .max_i     (max_i),
    .max_o     (max_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  maxpool #(.N(N)) u_dp (
    .clk      (clk),
    .max_clr  (max_clr),
    .max_en   (max_en),
    .max_pool (max_pool),
    .max_i    (max_i),
    .max_o    (max_o)
  );

endmodule

// File: rtl/maxpool_ctrl.sv
// Window controller for the maxpool datapath: counts elements per window,
// sequences set/pool updates and presents each pooled result on a valid/ready port.
module maxpool_ctrl
  import maxpool_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [W-1:0] win_size,
  input  logic         flush,
  output logic         max_en,
  output logic         max_clr,
  output logic         max_pool,
  output logic [N-1:0] max_i,
  input  logic [N-1:0] max_o,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output state_e       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never depends on ready, and a raised out_valid holds with stable data until taken.

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] win_q, win_d;
  logic         out_valid_q, out_valid_d;
  state_e       state_q, state_d;

  logic         accept;
  logic         first;
  logic [W-1:0] eff_win;
  logic         last;
  logic         flush_close;
  logic         close;

  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    accept      = in_valid && in_ready;
    first       = (cnt_q == '0);
    // A zero window length behaves as a window of one element.
    eff_win     = first ? ((win_size == '0) ? W'(1) : win_size) : win_q;
    last        = accept && (cnt_q == (eff_win - W'(1)));
    flush_close = flush && in_ready && (accept || !first);
    close       = last || flush_close;

    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + W'(1);
    end
    if (close) begin
      cnt_d = '0;
    end

    win_d = win_q;
    if (accept && first) begin
      win_d = eff_win;
    end

    out_valid_d = out_valid_q;
    if (close) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    state_d = state_of(cnt_d != '0, out_valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      win_q       <= W'(1);
      out_valid_q <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
    end
  end

  // The datapath has no reset of its own, so it is cleared while rst_n is low.
  assign max_clr   = !rst_n;
  assign max_en    = accept && rst_n;
  assign max_pool  = !first;
  assign max_i     = in_data;
  assign out_valid = out_valid_q;
  assign out_data  = max_o;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Directed bench for maxpool_ctrl with a behavioural running-max register on max_o.
module tb_maxpool_ctrl;
  import maxpool_pkg::*;

  localparam int N = 32;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic [W-1:0] win_size = '0;
  logic         flush = 1'b0;
  logic         max_en, max_clr, max_pool;
  logic [N-1:0] max_i;
  logic [N-1:0] max_o;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_data;
  state_e       dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // environment datapath: signed running maximum
  logic signed [N-1:0] ref_q;
  always @(posedge clk or posedge max_clr) begin
    if (max_clr) ref_q <= '0;
    else if (max_en) ref_q <= (max_pool && (ref_q > $signed(max_i))) ? ref_q : $signed(max_i);
  end
  assign max_o = ref_q;

  maxpool_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .win_size  (win_size),
    .flush     (flush),
    .max_en    (max_en),
    .max_clr   (max_clr),
    .max_pool  (max_pool),
    .max_i     (max_i),
    .max_o     (max_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = N'(123);
    tick(); tick();
    checks++;
    if (max_clr !== 1'b1) begin errors++; $display("FAIL reset_clr: got %b exp 1", max_clr); end
    checks++;
    if ({max_en, max_pool, out_valid, in_ready} !== 4'b0001) begin
      errors++; $display("FAIL reset_outs: en/pool/ov/ir got %b exp 0001", {max_en, max_pool, out_valid, in_ready});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE); end
    in_valid = 1'b0; rst_n = 1'b1;
    #1;
    checks++;
    if (max_clr !== 1'b0) begin errors++; $display("FAIL release_clr: got %b exp 0", max_clr); end
    tick();
  endtask

  task automatic test_basic();
    int d[4]   = '{3, -7, 9, 2};
    logic p[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    win_size = 4'd4; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = N'(d[i]);
      #1;
      checks++;
      if ({in_ready, max_en, max_pool, out_valid} !== {2'b11, p[i], 1'b0}) begin
        errors++; $display("FAIL basic_ctl[%0d]: ir/en/pool/ov got %b exp %b", i, {in_ready, max_en, max_pool, out_valid}, {2'b11, p[i], 1'b0});
      end
      checks++;
      if (max_i !== N'(d[i])) begin errors++; $display("FAIL basic_max_i[%0d]: got %0d exp %0d", i, $signed(max_i), d[i]); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data} !== {1'b1, N'(9)}) begin
      errors++; $display("FAIL basic_out: ov %b data %0d exp ov 1 data 9", out_valid, $signed(out_data));
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: ov got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int d[4]    = '{-5, -3, -8, -1};
    logic p[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic ov[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int od[5]   = '{0, 0, -3, 0, -1};
    win_size = 4'd2; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      in_data = (i < 4) ? N'(d[i]) : '0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b exp 1", i, in_ready); end
      checks++;
      if (out_valid !== ov[i]) begin errors++; $display("FAIL b2b_ov[%0d]: got %b exp %b", i, out_valid, ov[i]); end
      if (ov[i]) begin
        checks++;
        if (out_data !== N'(od[i])) begin errors++; $display("FAIL b2b_data[%0d]: got %0d exp %0d", i, $signed(out_data), od[i]); end
      end
      if (i < 4) begin
        checks++;
        if (max_pool !== p[i]) begin errors++; $display("FAIL b2b_pool[%0d]: got %b exp %b", i, max_pool, p[i]); end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    int d[3] = '{1, 4, 2};
    win_size = 4'd3; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = N'(d[i]);
      tick();
    end
    in_data = N'(100); flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({out_valid, in_ready, max_en, out_data} !== {3'b100, N'(4)}) begin
        errors++; $display("FAIL stall[%0d]: ov/ir/en %b data %0d exp 100 data 4", i, {out_valid, in_ready, max_en}, $signed(out_data));
      end
      tick();
    end
    flush = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if ({in_ready, max_en, max_pool, out_valid, out_data} !== {4'b1101, N'(4)}) begin
      errors++; $display("FAIL stall_release: ir/en/pool/ov %b data %0d exp 1101 data 4", {in_ready, max_en, max_pool, out_valid}, $signed(out_data));
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, max_pool} !== 2'b01) begin errors++; $display("FAIL stall_after: ov/pool got %b exp 01", {out_valid, max_pool}); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data} !== {1'b1, N'(100)}) begin
      errors++; $display("FAIL stall_flush: ov %b data %0d exp ov 1 data 100", out_valid, $signed(out_data));
    end
    tick();
  endtask

  task automatic test_flush();
    win_size = 4'd8; out_ready = 1'b1;
    in_valid = 1'b1; in_data = N'(6);
    tick();
    win_size = 4'd2; in_data = N'(11);
    #1;
    checks++;
    if (max_pool !== 1'b1) begin errors++; $display("FAIL flush_pool1: got %b exp 1", max_pool); end
    tick();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if ({out_valid, dbg_state} !== {1'b0, ST_ACC}) begin
      errors++; $display("FAIL flush_latched_win: ov/state got %b exp 0 %b", {out_valid, dbg_state}, ST_ACC);
    end
    tick();
    win_size = 4'd8; in_valid = 1'b1; in_data = N'(7);
    #1;
    checks++;
    if ({out_valid, out_data} !== {1'b1, N'(11)}) begin
      errors++; $display("FAIL flush_partial: ov %b data %0d exp ov 1 data 11", out_valid, $signed(out_data));
    end
    checks++;
    if ({max_en, max_pool} !== 2'b10) begin errors++; $display("FAIL flush_next_first: en/pool got %b exp 10", {max_en, max_pool}); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, max_pool} !== {1'b1, N'(7), 1'b0}) begin
      errors++; $display("FAIL flush_with_accept: ov %b data %0d pool %b exp 1 7 0", out_valid, $signed(out_data), max_pool);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_ignored: ov got %b exp 0", out_valid); end
  endtask

  task automatic test_win_zero();
    win_size = 4'd0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = N'(5);
    #1;
    checks++;
    if (max_pool !== 1'b0) begin errors++; $display("FAIL win0_pool: got %b exp 0", max_pool); end
    tick();
    in_data = N'(-2);
    #1;
    checks++;
    if ({out_valid, out_data, max_pool} !== {1'b1, N'(5), 1'b0}) begin
      errors++; $display("FAIL win0_first: ov %b data %0d pool %b exp 1 5 0", out_valid, $signed(out_data), max_pool);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data} !== {1'b1, N'(-2)}) begin
      errors++; $display("FAIL win0_second: ov %b data %0d exp ov 1 data -2", out_valid, $signed(out_data));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int d[4] = '{1, 2, 3, 4};
    win_size = 4'd4; out_ready = 1'b1;
    in_valid = 1'b1; in_data = N'(10); tick();
    in_data = N'(20); tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({max_clr, out_valid, max_pool} !== 3'b100) begin
      errors++; $display("FAIL rstmid_async: clr/ov/pool got %b exp 100", {max_clr, out_valid, max_pool});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({out_valid, max_clr} !== 2'b00) begin errors++; $display("FAIL rstmid_release: ov/clr got %b exp 00", {out_valid, max_clr}); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = N'(d[i]);
      #1;
      checks++;
      if ({out_valid, max_pool} !== {1'b0, (i != 0)}) begin
        errors++; $display("FAIL rstmid_win[%0d]: ov/pool got %b exp %b", i, {out_valid, max_pool}, {1'b0, (i != 0)});
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data} !== {1'b1, N'(4)}) begin
      errors++; $display("FAIL rstmid_out: ov %b data %0d exp ov 1 data 4", out_valid, $signed(out_data));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_flush();
    test_win_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
